// File: rtl/acc_access_ctrl.sv
// acc_access_ctrl: request/response front end for a 4-entry 8-bit accumulator
// register file. It handles READ, WRITE, ADD (read-modify-write) and CLEAR.
// All outputs are registered; each one is loaded for the state being entered.
//
// state | meaning
// IDLE  | reqReady=1, waiting for a request
// RD    | rfAddress driven, rfOutData captured into holdReg
// WR    | one-cycle write strobe with computed write data
// RESP  | rspValid=1, waiting for rspReady
module acc_access_ctrl #(
  parameter int ADDR_W = 13,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reqValid,
  output logic              reqReady,
  input  logic [1:0]        reqOp,
  input  logic [IDX_W-1:0]  reqIdx,
  input  logic [7:0]        reqData,
  output logic              rspValid,
  input  logic              rspReady,
  output logic [7:0]        rspData,
  output logic              rspCarry,
  output logic [ADDR_W-1:0] rfAddress,
  output logic [7:0]        rfInData,
  output logic              rfWriteEn,
  input  logic [7:0]        rfOutData
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_CLEAR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t     state;
  logic [1:0] opReg;
  logic [7:0] dataReg;
  logic [7:0] holdReg;
  logic       carryReg;

  // The ADD sum is taken from rfOutData directly on the RD->WR edge, which is
  // the same value holdReg captures on that edge.
  logic [8:0] addSum;
  assign addSum = {1'b0, rfOutData} + {1'b0, dataReg};

  // Sequencer: state, latched request and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      opReg     <= OP_READ;
      dataReg   <= 8'h00;
      holdReg   <= 8'h00;
      carryReg  <= 1'b0;
      reqReady  <= 1'b1;
      rspValid  <= 1'b0;
      rspData   <= 8'h00;
      rspCarry  <= 1'b0;
      rfAddress <= '0;
      rfInData  <= 8'h00;
      rfWriteEn <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (reqValid) begin
            opReg     <= reqOp;
            dataReg   <= reqData;
            reqReady  <= 1'b0;
            rfAddress <= {{(ADDR_W-IDX_W){1'b0}}, reqIdx};
            if (reqOp == OP_READ || reqOp == OP_ADD) begin
              state <= RD;
            end else begin
              state     <= WR;
              rfWriteEn <= 1'b1;
              rfInData  <= (reqOp == OP_WRITE) ? reqData : 8'h00;
            end
          end
        end
        RD: begin
          holdReg <= rfOutData;
          if (opReg == OP_ADD) begin
            state     <= WR;
            rfWriteEn <= 1'b1;
            rfInData  <= addSum[7:0];
            carryReg  <= addSum[8];
          end else begin
            state    <= RESP;
            rspValid <= 1'b1;
            rspData  <= rfOutData;
            rspCarry <= 1'b0;
          end
        end
        WR: begin
          state     <= RESP;
          rfWriteEn <= 1'b0;
          rfInData  <= 8'h00;
          rspValid  <= 1'b1;
          rspData   <= rfInData;
          rspCarry  <= (opReg == OP_ADD) ? carryReg : 1'b0;
        end
        RESP: begin
          if (rspReady) begin
            state     <= IDLE;
            rspValid  <= 1'b0;
            reqReady  <= 1'b1;
            rfAddress <= '0;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
